// File: rtl/mips_bus_pkg.sv
// Shared bus-arbiter types: grant-state encoding and requester owner codes.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts consecutive stalled grant cycles; expired is high once the count equals TIMEOUT.
// Latency: expired is registered-count based, so it rises the cycle after the TIMEOUT-th stall.
// Backpressure: none; clear wins over stall. TIMEOUT=0 ties expired low.
module arb_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (TIMEOUT != 0) && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (stall && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-style memory port between instruction-fetch and data requesters.
// Latency: grant registered, ack combinational on the first non-stalled grant cycle (min 2 cycles).
// Backpressure: mem_waitrequest holds the grant; timeout aborts with err. Option: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ack,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  err,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic                  mem_waitrequest,
  input  logic [DATA_W-1:0]     mem_readdata
);

  arb_state_t state_q, state_d;
  logic       expired;
  logic       pick_d;
  logic       done;

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .stall   ((state_q != IDLE) && mem_waitrequest),
    .expired (expired)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On contention the requester that did not own the bus last goes first.
  assign pick_d = d_req && (!i_req || (last_q == OWNER_I));

  always_comb begin
    last_d = last_q;
    if (i_ack) begin
      last_d = OWNER_I;
    end else if (d_ack) begin
      last_d = OWNER_D;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= OWNER_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  assign done = expired || !mem_waitrequest;

  always_comb begin
    state_d        = state_q;
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    i_ack          = 1'b0;
    i_rdata        = '0;
    d_ack          = 1'b0;
    d_rdata        = '0;
    err            = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = GRANT_D;
        end else if (i_req) begin
          state_d = GRANT_I;
        end
      end
      GRANT_I: begin
        mem_address    = i_addr;
        mem_byteenable = '1;
        mem_read       = !expired;
        if (done) begin
          i_ack   = 1'b1;
          err     = expired;
          i_rdata = expired ? '0 : mem_readdata;
          state_d = IDLE;
        end
      end
      GRANT_D: begin
        mem_address    = d_addr;
        mem_byteenable = d_be;
        mem_writedata  = d_wdata;
        // Strobes are withdrawn in the abort cycle so memory never sees a late completion.
        mem_read       = !expired && !d_we;
        mem_write      = !expired && d_we;
        if (done) begin
          d_ack   = 1'b1;
          err     = expired;
          d_rdata = (expired || d_we) ? '0 : mem_readdata;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
